// File: rtl/alu8_pkg.sv
// alu8_pkg: shared definitions for the ALU command sequencer slice.
//   - DW_DEFAULT : default datapath width
//   - OP_*       : ALU mode encodings driven on alu_mode
//   - state_t    : sequencer FSM states
package alu8_pkg;

    localparam int unsigned DW_DEFAULT = 8;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu8_regfile.sv
// alu8_regfile: NREG x DW operand register file.
//   clk, rst_n           : clock, async active-low reset (clears all entries)
//   host_we/addr/data    : host write port
//   wb_we/addr/data      : result writeback port, wins over the host port
//   rd_addr_a/rd_data_a  : combinational read port A
//   rd_addr_b/rd_data_b  : combinational read port B
// Read ports forward same-cycle host write data (write-first).
module alu8_regfile
    import alu8_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] rd_addr_a,
    output logic [DW-1:0] rd_data_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_b
);

    logic [NREG-1:0][DW-1:0] mem_q;
    logic [NREG-1:0][DW-1:0] mem_d;

    // Writeback applied after the host write so it takes priority on collision.
    always_comb begin
        mem_d = mem_q;
        if (host_we) mem_d[host_addr] = host_data;
        if (wb_we)   mem_d[wb_addr]   = wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '0;
        else        mem_q <= mem_d;
    end

    assign rd_data_a = (host_we && host_addr == rd_addr_a) ? host_data : mem_q[rd_addr_a];
    assign rd_data_b = (host_we && host_addr == rd_addr_b) ? host_data : mem_q[rd_addr_b];

endmodule

// File: rtl/alu8_cmd_seq.sv
// alu8_cmd_seq: command-side initiator for a combinational two-operand ALU.
//   clk, rst_n                 : clock, async active-low reset
//   wr_en/wr_addr/wr_data      : host register-file write
//   cmd_valid/cmd_ready        : command handshake (ready only in IDLE)
//   cmd_op/src_a/src_b/dst     : ALU op and register addresses
//   alu_left/right/mode        : registered ALU inputs, held between commands
//   alu_result                 : combinational ALU output, sampled in ISSUE
//   rsp_valid/ready/data/zero  : result handshake, held until accepted
module alu8_cmd_seq
    import alu8_pkg::*;
#(
    parameter int DW   = DW_DEFAULT,
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [AW-1:0] cmd_src_a,
    input  logic [AW-1:0] cmd_src_b,
    input  logic [AW-1:0] cmd_dst,
    output logic [DW-1:0] alu_left,
    output logic [DW-1:0] alu_right,
    output logic [1:0]    alu_mode,
    input  logic [DW-1:0] alu_result,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_zero
);

    state_t        state_q, state_d;
    logic [DW-1:0] alu_left_q, alu_left_d;
    logic [DW-1:0] alu_right_q, alu_right_d;
    logic [1:0]    alu_mode_q, alu_mode_d;
    logic [AW-1:0] dst_q, dst_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [DW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_zero_q, rsp_zero_d;

    logic          wb_we;
    logic [DW-1:0] rd_a, rd_b;

    alu8_regfile #(
        .DW   (DW),
        .NREG (NREG),
        .AW   (AW)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .host_we   (wr_en),
        .host_addr (wr_addr),
        .host_data (wr_data),
        .wb_we     (wb_we),
        .wb_addr   (dst_q),
        .wb_data   (alu_result),
        .rd_addr_a (cmd_src_a),
        .rd_data_a (rd_a),
        .rd_addr_b (cmd_src_b),
        .rd_data_b (rd_b)
    );

    always_comb begin
        state_d     = state_q;
        alu_left_d  = alu_left_q;
        alu_right_d = alu_right_q;
        alu_mode_d  = alu_mode_q;
        dst_d       = dst_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        wb_we       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    alu_left_d  = rd_a;
                    alu_right_d = rd_b;
                    alu_mode_d  = cmd_op;
                    dst_d       = cmd_dst;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                wb_we       = 1'b1;
                rsp_data_d  = alu_result;
                rsp_zero_d  = (alu_result == '0);
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alu_left_q  <= '0;
            alu_right_q <= '0;
            alu_mode_q  <= '0;
            dst_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_left_q  <= alu_left_d;
            alu_right_q <= alu_right_d;
            alu_mode_q  <= alu_mode_d;
            dst_q       <= dst_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign alu_left  = alu_left_q;
    assign alu_right = alu_right_q;
    assign alu_mode  = alu_mode_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

endmodule
